cci_mpf_svc_vtp_tlb_dm: RTL and testbench
=========================================

Name: cci_mpf_svc_vtp_tlb_dm

Overview:
Direct-mapped 4KB-page TLB; it is the server side of the VTP TLB lookup/fill interface.
- Sits between the VTP pipeline (lookup client) and the page table walker (fill source).
- Returns a hit or a miss exactly 2 cycles after an accepted lookup.
- Accepts one-entry fills from the walker, and self-clears after reset and on an invalidate request.

Parameters:
NUM_SETS, 512, entry count; power of 2, ≥4; IDX_BITS = log2(NUM_SETS)
VA_IDX_BITS, 36, 4KB VA page index width (42 line-address bits − 6)
PA_IDX_BITS, 26, 4KB PA page index width (32 − 6)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
lookupEn  in  1  lookup request; ignored unless lookupRdy
lookupPageVA  in  VA_IDX_BITS  4KB VA page to translate
lookupRdy  out  1  lookup may be accepted this cycle
lookupRspValid  out  1  hit result, one cycle
lookupRspPagePA  out  PA_IDX_BITS  translated PA page; meaningful with lookupRspValid
lookupRspIsBigPage  out  1  stored big-page flag; meaningful with lookupRspValid
lookupMiss  out  1  miss result, one cycle
lookupMissVA  out  VA_IDX_BITS  VA of the missing lookup; meaningful with lookupMiss
fillEn  in  1  fill request; ignored unless fillRdy
fillVA  in  VA_IDX_BITS  VA page to install
fillPA  in  PA_IDX_BITS  PA page to install
fillBigPage  in  1  flag stored with the entry
fillRdy  out  1  fill buffer empty and not in SWEEP
invalEn  in  1  invalidate all entries (one-cycle pulse)

Behaviour:
- Interface: one clock (clk); reset_n asynchronous active-low.
- Address split: set index = VA[IDX_BITS-1:0]; tag = VA[VA_IDX_BITS-1:IDX_BITS] (27 bits at default).
- Entry = {valid, tag, PA, big} (55 bits at default), held in a 1R1W synchronous RAM; the RAM itself is not reset.
- Reset values: lookupRdy=0, fillRdy=0, lookupRspValid=0, lookupMiss=0, lookupRspPagePA=0, lookupMissVA=0, lookupRspIsBigPage=0; sweep counter=0; fill buffer empty; state=SWEEP.
- State machine:
  - SWEEP: write valid=0 to set[counter], counter++ each cycle; after NUM_SETS cycles go to RUN. lookupRdy=0 and fillRdy=0 throughout.
  - RUN: lookupRdy = !fillBufFull; fillRdy = !fillBufFull.
  - invalEn in RUN: counter=0, go to SWEEP next cycle; a pending fill buffer is discarded.
  - invalEn during SWEEP: restart the counter at 0.
- Lookup pipeline (accept at cycle T):
  - T: RAM read issued; VA captured.
  - T+1: RAM data registered alongside the VA.
  - T+2: compare valid and tag. Hit: lookupRspValid=1 with PA and big flag. Otherwise: lookupMiss=1, lookupMissVA=VA.
  - Exactly one of lookupRspValid/lookupMiss is asserted per accepted lookup, in request order.
  - Throughput is 1 lookup/cycle.
- Fill:
  - Accepted fill is latched in a one-entry buffer at cycle F.
  - At F+1 the RAM is written with valid=1 and the buffer clears. lookupRdy=0 during F+1, so the write never collides with a read.
  - Earliest lookup that observes the new entry is accepted at F+2.
  - Lookups already in flight return pre-fill contents; a miss there is legal.
  - Fill to an occupied set overwrites it (no victim logic).
- Simultaneous events:
  - lookupEn & fillEn in the same cycle: both are accepted.
  - invalEn & fillEn in the same cycle: the fill is dropped.
- Lookups in flight when invalEn arrives complete using the RAM contents already read.
- reset_n asserted mid-operation: all valid pulses drop immediately; the block re-enters SWEEP.
- Outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared VTP package: VA/PA 4KB page-index typedefs and width constants, page-offset constants.
- Local to this block: entry struct and IDX_BITS.
- One sub-module, cci_mpf_prim_ram_simple: parameterized 1R1W RAM with registered read data (1-cycle read latency, no reset).

Test Plan:
- Reset, release reset_n: lookupRdy stays 0 for exactly 512 cycles, then 1. Lookup VA=0x000000123 at T → lookupMiss at T+2, lookupMissVA=0x000000123.
- Fill VA=0x000000123, PA=0x0ABCDEF, big=0 at F: lookupRdy=0 at F+1. Lookup same VA at F+2 → lookupRspValid at F+4, PA=0x0ABCDEF, big=0.
- Tag conflict: fill VA=0x000000123, then lookup VA=0x000000323 (same set 0x123, different tag) → miss. Fill 0x323 with PA=0x1, then lookup 0x123 → miss (overwritten).
- Back-to-back 8 lookups, alternating hit (filled VA 0x5/0x6) and miss, no fill pending: 8 responses on consecutive cycles, in order, each exactly one of valid/miss.
- After fills of VA 0x5 and 0x6, pulse invalEn: lookupRdy low 512 cycles. Afterwards lookups of VA 0x5/0x6 miss.
- Assert reset_n=0 mid-stream with 2 lookups in flight: lookupRspValid and lookupMiss are 0 in the same cycle reset asserts, with no further responses. Full sweep repeats after release.

Source files
------------

// File: rtl/cci_mpf_svc_vtp_tlb_dm_pkg.sv
// Shared VTP definitions: 4KB page-index widths and typedefs, page-offset
// constants, and the TLB sweep/run state encoding.
package cci_mpf_svc_vtp_tlb_dm_pkg;

   // Line-address widths (64-byte lines).
   localparam int CCI_MPF_VA_LINE_BITS = 42;
   localparam int CCI_MPF_PA_LINE_BITS = 32;

   // Lines within a 4KB page.
   localparam int VTP_4KB_PAGE_OFFSET_BITS = 6;

   // 4KB page-index widths.
   localparam int VTP_VA_IDX_BITS = CCI_MPF_VA_LINE_BITS - VTP_4KB_PAGE_OFFSET_BITS;
   localparam int VTP_PA_IDX_BITS = CCI_MPF_PA_LINE_BITS - VTP_4KB_PAGE_OFFSET_BITS;

   typedef logic [VTP_VA_IDX_BITS-1:0] t_tlb_4kb_va_page_idx;
   typedef logic [VTP_PA_IDX_BITS-1:0] t_tlb_4kb_pa_page_idx;

   // TLB state machine encoding.
   localparam logic [0:0] TLB_ST_SWEEP = 1'b0;
   localparam logic [0:0] TLB_ST_RUN   = 1'b1;

endpackage

// File: rtl/cci_mpf_prim_ram_simple.sv
// Simple 1R1W RAM with registered read data (1-cycle read latency).
// Contents and read register are not reset.
//   clk      : clock
//   i_wen    : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, sampled every cycle
//   o_rdata  : read data, valid the cycle after i_raddr is presented
module cci_mpf_prim_ram_simple #(
   parameter  int N_ENTRIES   = 512,
   parameter  int N_DATA_BITS = 8,
   localparam int A_BITS      = $clog2(N_ENTRIES)
)(
   input  logic                   clk,
   input  logic                   i_wen,
   input  logic [A_BITS-1:0]      i_waddr,
   input  logic [N_DATA_BITS-1:0] i_wdata,
   input  logic [A_BITS-1:0]      i_raddr,
   output logic [N_DATA_BITS-1:0] o_rdata
);

   logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];

   always_ff @(posedge clk) begin
      if (i_wen) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/cci_mpf_svc_vtp_tlb_dm.sv
// Direct-mapped 4KB-page VTP TLB. Serves lookups from the VTP pipeline with a
// fixed 2-cycle hit/miss response and accepts single-entry fills from the
// page table walker. Clears itself by sweeping every set after reset and on
// invalidate.
//   clk, reset_n        : clock, async active-low reset
//   lookupEn/PageVA     : lookup request (accepted when lookupRdy)
//   lookupRdy           : lookup may be accepted this cycle
//   lookupRspValid/...  : hit response with PA page and big-page flag
//   lookupMiss/MissVA   : miss response with the missing VA page
//   fillEn/VA/PA/Big    : fill request (accepted when fillRdy)
//   fillRdy             : fill buffer empty and not sweeping
//   invalEn             : invalidate all entries
module cci_mpf_svc_vtp_tlb_dm
   import cci_mpf_svc_vtp_tlb_dm_pkg::*;
#(
   parameter int NUM_SETS    = 512,
   parameter int VA_IDX_BITS = VTP_VA_IDX_BITS,
   parameter int PA_IDX_BITS = VTP_PA_IDX_BITS
)(
   input  logic                   clk,
   input  logic                   reset_n,

   input  logic                   lookupEn,
   input  logic [VA_IDX_BITS-1:0] lookupPageVA,
   output logic                   lookupRdy,
   output logic                   lookupRspValid,
   output logic [PA_IDX_BITS-1:0] lookupRspPagePA,
   output logic                   lookupRspIsBigPage,
   output logic                   lookupMiss,
   output logic [VA_IDX_BITS-1:0] lookupMissVA,

   input  logic                   fillEn,
   input  logic [VA_IDX_BITS-1:0] fillVA,
   input  logic [PA_IDX_BITS-1:0] fillPA,
   input  logic                   fillBigPage,
   output logic                   fillRdy,

   input  logic                   invalEn
);

   localparam int IDX_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = VA_IDX_BITS - IDX_BITS;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SETS - 1);

   typedef struct packed {
      logic                   valid;
      logic [TAG_BITS-1:0]    tag;
      logic [PA_IDX_BITS-1:0] pa;
      logic                   big;
   } t_entry;

   localparam int ENTRY_BITS = $bits(t_entry);

   // Control state
   logic [0:0]          r_state;
   logic [IDX_BITS-1:0] r_cnt;
   logic                r_fill_full;
   logic [IDX_BITS-1:0] r_fill_idx;
   t_entry              r_fill_ent;
   logic                r_lookupRdy;
   logic                r_fillRdy;

   logic [0:0]          w_state_nxt;
   logic [IDX_BITS-1:0] w_cnt_nxt;
   logic                w_full_nxt;
   logic                w_lookup_acc;
   logic                w_fill_acc;

   // RAM ports
   logic                w_ram_wen;
   logic [IDX_BITS-1:0] w_ram_waddr;
   t_entry              w_ram_wdata;
   t_entry              w_ram_rdata;

   // Lookup pipeline
   logic                   r_vld1;
   logic [VA_IDX_BITS-1:0] r_va1;
   logic                   w_hit;

   logic                   r_rspValid;
   logic [PA_IDX_BITS-1:0] r_rspPA;
   logic                   r_rspBig;
   logic                   r_miss;
   logic [VA_IDX_BITS-1:0] r_missVA;

   assign lookupRdy          = r_lookupRdy;
   assign fillRdy            = r_fillRdy;
   assign lookupRspValid     = r_rspValid;
   assign lookupRspPagePA    = r_rspPA;
   assign lookupRspIsBigPage = r_rspBig;
   assign lookupMiss         = r_miss;
   assign lookupMissVA       = r_missVA;

   assign w_lookup_acc = lookupEn & r_lookupRdy;
   // An invalidate in the same cycle wins over a new fill.
   assign w_fill_acc   = fillEn & r_fillRdy & ~invalEn;

   // Next state and the single RAM write port (sweep clear or fill commit).
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_full_nxt  = r_fill_full;
      w_ram_wen   = 1'b0;
      w_ram_waddr = r_cnt;
      w_ram_wdata = '0;

      if (r_state == TLB_ST_SWEEP) begin
         w_ram_wen = 1'b1;
         if (invalEn) begin
            w_cnt_nxt = '0;
         end else if (r_cnt == LAST_IDX) begin
            w_state_nxt = TLB_ST_RUN;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt + IDX_BITS'(1);
         end
      end else if (invalEn) begin
         // Pending fill is discarded; it would otherwise survive the sweep.
         w_state_nxt = TLB_ST_SWEEP;
         w_cnt_nxt   = '0;
         w_full_nxt  = 1'b0;
      end else begin
         // lookupRdy is low while the buffer is full, so this write never
         // meets a lookup read in the same cycle.
         if (r_fill_full) begin
            w_ram_wen   = 1'b1;
            w_ram_waddr = r_fill_idx;
            w_ram_wdata = r_fill_ent;
            w_full_nxt  = 1'b0;
         end
         if (w_fill_acc) w_full_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= TLB_ST_SWEEP;
         r_cnt       <= '0;
         r_fill_full <= 1'b0;
         r_fill_idx  <= '0;
         r_fill_ent  <= '0;
         r_lookupRdy <= 1'b0;
         r_fillRdy   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_fill_full <= w_full_nxt;
         // Ready flags are computed from next state so they are registered.
         r_lookupRdy <= (w_state_nxt == TLB_ST_RUN) & ~w_full_nxt;
         r_fillRdy   <= (w_state_nxt == TLB_ST_RUN) & ~w_full_nxt;
         if (w_fill_acc) begin
            r_fill_idx       <= fillVA[IDX_BITS-1:0];
            r_fill_ent.valid <= 1'b1;
            r_fill_ent.tag   <= fillVA[VA_IDX_BITS-1:IDX_BITS];
            r_fill_ent.pa    <= fillPA;
            r_fill_ent.big   <= fillBigPage;
         end
      end
   end

   cci_mpf_prim_ram_simple #(
      .N_ENTRIES   (NUM_SETS),
      .N_DATA_BITS (ENTRY_BITS)
   ) ram (
      .clk     (clk),
      .i_wen   (w_ram_wen),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_raddr (lookupPageVA[IDX_BITS-1:0]),
      .o_rdata (w_ram_rdata)
   );

   // RAM data arrives in T+1 next to the captured VA; the compare result is
   // registered straight into the outputs so they are visible in T+2.
   assign w_hit = w_ram_rdata.valid &&
                  (w_ram_rdata.tag == r_va1[VA_IDX_BITS-1:IDX_BITS]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld1     <= 1'b0;
         r_va1      <= '0;
         r_rspValid <= 1'b0;
         r_rspPA    <= '0;
         r_rspBig   <= 1'b0;
         r_miss     <= 1'b0;
         r_missVA   <= '0;
      end else begin
         r_vld1     <= w_lookup_acc;
         if (w_lookup_acc) r_va1 <= lookupPageVA;
         r_rspValid <= r_vld1 & w_hit;
         r_miss     <= r_vld1 & ~w_hit;
         if (r_vld1 & w_hit) begin
            r_rspPA  <= w_ram_rdata.pa;
            r_rspBig <= w_ram_rdata.big;
         end
         if (r_vld1 & ~w_hit) r_missVA <= r_va1;
      end
   end

endmodule

// File: tb/tb_cci_mpf_svc_vtp_tlb_dm.sv
// Self-checking bench for the direct-mapped VTP TLB. A reference model of the
// TLB contents predicts each lookup result when the lookup is accepted; the
// prediction is queued and compared when the DUT responds.
module tb_cci_mpf_svc_vtp_tlb_dm;

   localparam int NS  = 512;
   localparam int VAW = 36;
   localparam int PAW = 26;
   localparam int IB  = 9;

   logic            clk;
   logic            reset_n;
   logic            lookupEn;
   logic [VAW-1:0]  lookupPageVA;
   logic            lookupRdy;
   logic            lookupRspValid;
   logic [PAW-1:0]  lookupRspPagePA;
   logic            lookupRspIsBigPage;
   logic            lookupMiss;
   logic [VAW-1:0]  lookupMissVA;
   logic            fillEn;
   logic [VAW-1:0]  fillVA;
   logic [PAW-1:0]  fillPA;
   logic            fillBigPage;
   logic            fillRdy;
   logic            invalEn;

   cci_mpf_svc_vtp_tlb_dm #(
      .NUM_SETS    (NS),
      .VA_IDX_BITS (VAW),
      .PA_IDX_BITS (PAW)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .lookupEn           (lookupEn),
      .lookupPageVA       (lookupPageVA),
      .lookupRdy          (lookupRdy),
      .lookupRspValid     (lookupRspValid),
      .lookupRspPagePA    (lookupRspPagePA),
      .lookupRspIsBigPage (lookupRspIsBigPage),
      .lookupMiss         (lookupMiss),
      .lookupMissVA       (lookupMissVA),
      .fillEn             (fillEn),
      .fillVA             (fillVA),
      .fillPA             (fillPA),
      .fillBigPage        (fillBigPage),
      .fillRdy            (fillRdy),
      .invalEn            (invalEn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic           miss;
      logic [VAW-1:0] va;
      logic [PAW-1:0] pa;
      logic           big;
      int             cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model of TLB contents plus the one-entry fill buffer.
   logic           m_valid [NS];
   logic [VAW-IB-1:0] m_tag [NS];
   logic [PAW-1:0] m_pa    [NS];
   logic           m_big   [NS];
   logic           p_vld;
   logic [VAW-1:0] p_va;
   logic [PAW-1:0] p_pa;
   logic           p_big;

   logic s_lrdy, s_frdy, s_acc, s_facc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      p_vld = 1'b0;
   endtask

   // One clock of stimulus. Entered and left at posedge+1.
   task automatic do_cycle(input logic le, input logic [VAW-1:0] va,
                           input logic fe, input logic [VAW-1:0] fva,
                           input logic [PAW-1:0] fpa, input logic fbig,
                           input logic inv);
      exp_t x;
      int   idx;
      int   fidx;
      lookupEn = le; lookupPageVA = va;
      fillEn = fe; fillVA = fva; fillPA = fpa; fillBigPage = fbig;
      invalEn = inv;
      @(negedge clk);
      s_lrdy = lookupRdy;
      s_frdy = fillRdy;
      s_acc  = 1'b0;
      s_facc = 1'b0;
      // Lookup sees contents before any fill/invalidate of this cycle.
      if (le && lookupRdy) begin
         idx   = int'(va[IB-1:0]);
         x.miss = !(m_valid[idx] && (m_tag[idx] == va[VAW-1:IB]));
         x.va  = va;
         x.pa  = m_pa[idx];
         x.big = m_big[idx];
         x.cyc = cyc;
         sb.push_back(x);
         s_acc = 1'b1;
      end
      if (p_vld) begin
         if (!inv) begin
            fidx          = int'(p_va[IB-1:0]);
            m_valid[fidx] = 1'b1;
            m_tag[fidx]   = p_va[VAW-1:IB];
            m_pa[fidx]    = p_pa;
            m_big[fidx]   = p_big;
         end
         p_vld = 1'b0;
      end
      if (inv) model_clear();
      if (fe && fillRdy && !inv) begin
         p_vld = 1'b1; p_va = fva; p_pa = fpa; p_big = fbig;
         s_facc = 1'b1;
      end
      @(posedge clk); #1;
      lookupEn = 1'b0; fillEn = 1'b0; invalEn = 1'b0;
   endtask

   task automatic idle();
      do_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic lookup(input logic [VAW-1:0] va, output int tries);
      tries = 0;
      do begin
         do_cycle(1'b1, va, 1'b0, '0, '0, 1'b0, 1'b0);
         tries++;
      end while (!s_acc && tries < 50);
      if (!s_acc) chk("lookup_timeout", 64'(0), 64'(1));
   endtask

   task automatic fill(input logic [VAW-1:0] va, input logic [PAW-1:0] pa, input logic big);
      int tries = 0;
      do begin
         do_cycle(1'b0, '0, 1'b1, va, pa, big, 1'b0);
         tries++;
      end while (!s_facc && tries < 50);
      if (!s_facc) chk("fill_timeout", 64'(0), 64'(1));
   endtask

   // Counts cycles with lookupRdy low until it rises.
   task automatic wait_rdy(output int n);
      n = 0;
      forever begin
         idle();
         if (s_lrdy || n > 3000) break;
         n++;
      end
   endtask

   task automatic drain();
      repeat (4) idle();
   endtask

   // Response monitor / scoreboard check.
   always @(negedge clk) begin
      if (lookupRspValid || lookupMiss) begin
         chk("rsp_onehot", 64'(lookupRspValid & lookupMiss), 64'(0));
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 64'(1), 64'(0));
         end else begin
            e = sb.pop_front();
            chk("rsp_miss", 64'(lookupMiss), 64'(e.miss));
            chk("rsp_lat", 64'(cyc), 64'(e.cyc + 2));
            if (e.miss) begin
               chk("miss_va", 64'(lookupMissVA), 64'(e.va));
            end else begin
               chk("hit_pa", 64'(lookupRspPagePA), 64'(e.pa));
               chk("hit_big", 64'(lookupRspIsBigPage), 64'(e.big));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   initial begin
      int n;
      int tries;
      int acc;
      logic [VAW-1:0] bva;

      reset_n = 1'b0;
      lookupEn = 1'b0; lookupPageVA = '0;
      fillEn = 1'b0; fillVA = '0; fillPA = '0; fillBigPage = 1'b0;
      invalEn = 1'b0;
      model_clear();

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_lookupRdy", 64'(lookupRdy), 64'(0));
      chk("rst_fillRdy", 64'(fillRdy), 64'(0));
      chk("rst_rspValid", 64'(lookupRspValid), 64'(0));
      chk("rst_miss", 64'(lookupMiss), 64'(0));
      chk("rst_pa", 64'(lookupRspPagePA), 64'(0));
      chk("rst_missva", 64'(lookupMissVA), 64'(0));
      chk("rst_big", 64'(lookupRspIsBigPage), 64'(0));
      @(posedge clk); #1;
      reset_n = 1'b1;
      wait_rdy(n);
      chk("sweep_len_reset", 64'(n), 64'(512));

      // Cold miss
      lookup(36'h000000123, tries);
      drain();

      // Fill then hit at F+2
      fill(36'h000000123, 26'h0ABCDEF, 1'b0);
      idle();
      chk("lookupRdy_fill_f1", 64'(s_lrdy), 64'(0));
      chk("fillRdy_fill_f1", 64'(s_frdy), 64'(0));
      lookup(36'h000000123, tries);
      chk("fill_visible_f2", 64'(tries), 64'(1));
      drain();

      // Tag conflict and overwrite
      lookup(36'h000000323, tries);
      fill(36'h000000323, 26'h0000001, 1'b0);
      lookup(36'h000000123, tries);
      lookup(36'h000000323, tries);
      drain();

      // Back-to-back alternating hit/miss
      fill(36'h5, 26'h0000055, 1'b1);
      idle();
      fill(36'h6, 26'h0000066, 1'b0);
      idle();
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 1)      bva = 36'h100 + 36'(i);
         else if (i % 4 == 0) bva = 36'h5;
         else                 bva = 36'h6;
         do_cycle(1'b1, bva, 1'b0, '0, '0, 1'b0, 1'b0);
         if (s_acc) acc++;
      end
      chk("b2b_accepted", 64'(acc), 64'(8));
      drain();

      // Lookup and fill in the same cycle: lookup sees pre-fill contents
      do_cycle(1'b1, 36'h9, 1'b1, 36'h9, 26'h0000099, 1'b1, 1'b0);
      chk("simul_fill_acc", 64'(s_facc), 64'(1));
      lookup(36'h9, tries);
      drain();

      // Invalidate with a same-cycle fill: fill dropped, full sweep
      do_cycle(1'b0, '0, 1'b1, 36'hA, 26'h00000AA, 1'b0, 1'b1);
      wait_rdy(n);
      chk("sweep_len_inval", 64'(n), 64'(512));
      lookup(36'h5, tries);
      lookup(36'h6, tries);
      lookup(36'h9, tries);
      lookup(36'hA, tries);
      drain();

      // Invalidate while a fill is buffered: fill discarded
      fill(36'hB, 26'h00000BB, 1'b1);
      do_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      wait_rdy(n);
      chk("sweep_len_inval_pend", 64'(n), 64'(512));
      lookup(36'hB, tries);
      drain();

      // Reset mid-stream with lookups in flight
      fill(36'h7, 26'h0000077, 1'b0);
      idle();
      lookup(36'h7, tries);
      lookup(36'h8, tries);
      reset_n = 1'b0;
      #1;
      chk("midrst_rspValid", 64'(lookupRspValid), 64'(0));
      chk("midrst_miss", 64'(lookupMiss), 64'(0));
      chk("midrst_lookupRdy", 64'(lookupRdy), 64'(0));
      sb.delete();
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_rdy(n);
      chk("sweep_len_midrst", 64'(n), 64'(512));
      lookup(36'h7, tries);
      drain();

      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
